image_ram_arbiter: RTL and testbench
====================================

# image_ram_arbiter

Arbitrates the single-port image RAM between the VGA scanout path and CPU pixel writes. CPU writes are queued in a small FIFO and drained into free RAM cycles. Scanout reads keep priority. A starvation guard forces a write through when the queue has been full too long. The block sits between the CPU image-word decode, the VGA counter/pixel fetch, and the image RAM port.

## Interface
- ADDRESS_WIDTH, 14, image RAM address width
- DATA_WIDTH, 8, pixel (palette index) width
- FIFO_DEPTH, 8, write queue entries (power of 2, ≥2)
- STARVE_LIMIT, 64, consecutive full-and-blocked cycles before a forced write (≥1)

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  CPU write request
- wr_ready  out  1  queue can accept; equals !full
- wr_addr  in  ADDRESS_WIDTH  CPU write address
- wr_data  in  DATA_WIDTH  CPU write pixel
- scan_req  in  1  scanout needs a read this cycle
- scan_addr  in  ADDRESS_WIDTH  scanout read address
- active  in  1  VGA active-video flag
- scan_valid  out  1  scan_data valid (one cycle after a granted read)
- scan_data  out  DATA_WIDTH  pixel returned to scanout
- scan_miss  out  1  pulse aligned with where scan_valid would be; the read was pre-empted
- ram_addr  out  ADDRESS_WIDTH  RAM address
- ram_wEn  out  1  RAM write enable
- ram_dataIn  out  DATA_WIDTH  RAM write data
- ram_dataOut  in  DATA_WIDTH  RAM read data, registered, 1-cycle latency
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queue occupancy

## Operation
- Push: wr_valid && wr_ready at a clk edge enqueues {addr, data}.
  - Push and pop in the same cycle are allowed.
  - There is no bypass; an entry enters the RAM no earlier than the cycle after acceptance.
- Grant is decided combinationally each cycle, first match wins:
  - GNT_FORCE: full && scan_req && starve_cnt == STARVE_LIMIT-1. Pop the head and write it. The read is dropped.
  - GNT_READ: scan_req. ram_addr=scan_addr, ram_wEn=0.
  - GNT_WRITE: !empty && drain_ok. ram_addr/ram_dataIn = FIFO head, ram_wEn=1, pop.
  - GNT_NONE: ram_wEn=0, ram_addr=scan_addr.
- drain_ok is 1 unless set by the macro (see Configuration).
- starve_cnt:
  - Increments when full and the grant is not WRITE or FORCE.
  - Clears on any write grant, or when not full.
  - Saturates at STARVE_LIMIT-1.
- scan_valid is a registered copy of (grant==GNT_READ). scan_data = ram_dataOut (pass-through, aligned to scan_valid).
- scan_miss is a registered copy of (grant==GNT_FORCE).
- Boundary conditions:
  - Empty queue: no write grant.
  - Full queue: wr_ready=0 and the push is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Read-after-write ordering against scanout is not guaranteed; a pixel updates on the next frame.
- Reset mid-operation: the queue is flushed and queued writes are lost. An in-flight read produces no scan_valid.

## Timing
- Reset values: wr_ready=1, scan_valid=0, scan_miss=0, fifo_count=0, starve_cnt=0.
- ram_wEn is forced 0 while reset is high.
- Read latency: scan_req granted in cycle N gives scan_valid=1 in cycle N+1.
- Write latency: accepted at edge N, written at RAM edge N+1 at earliest.
- fifo_count updates on the edge of the push/pop.
- Worst-case forced-write interval: one per STARVE_LIMIT cycles while full under continuous scan_req.
- RAM-side outputs are combinational from registered state plus scan_req/scan_addr/active. There is no extra pipeline stage.

## Configuration
- IMAGE_ARB_BLANK_ONLY_EN
  - Defined: drain_ok = !active. Normal writes happen only during blanking. GNT_FORCE still applies during active video.
  - Undefined: drain_ok = 1. Writes fill any cycle without scan_req.

## Structure
- Package image_arb_pkg holds:
  - grant enum: GNT_NONE, GNT_READ, GNT_WRITE, GNT_FORCE
  - default width constants: ADDRESS_WIDTH/DATA_WIDTH defaults 14/8
- Sub-module image_wr_fifo: synchronous FIFO, width ADDRESS_WIDTH+DATA_WIDTH, with push/pop/full/empty/count.
- Grant logic, starve counter and the output registers live in the top.

## Test plan
- Idle, scan_req=0, 3 writes (0x0010/0x11, 0x0020/0x22, 0x3FFF/0xFF) -> ram_wEn on 3 consecutive cycles starting 1 cycle after the first accept, in order; fifo_count returns to 0.
- scan_req=1 at scan_addr=0x0005 with RAM preloaded 0xA5 -> scan_valid=1 and scan_data=0xA5 exactly 1 cycle later; a queued write waits until scan_req drops.
- Fill FIFO_DEPTH=8 under continuous scan_req -> wr_ready=0 at count 8; after STARVE_LIMIT cycles one forced write, scan_miss=1 for one cycle, fifo_count=7, wr_ready=1.
- Simultaneous push and pop at count 4 -> count stays 4, data order preserved.
- Reset asserted with count 5 and a read in flight -> next cycle count=0, scan_valid=0, ram_wEn=0; post-reset writes proceed normally.
- IMAGE_ARB_BLANK_ONLY_EN defined, active=1, scan_req=0, 2 queued writes -> no ram_wEn until active=0, then 2 writes on consecutive cycles.

Source files
------------

// File: rtl/image_arb_pkg.sv
// Shared types and default widths for the image RAM arbiter.
package image_arb_pkg;

  localparam int ADDRESS_WIDTH_DEF = 14;
  localparam int DATA_WIDTH_DEF    = 8;

  // Owner of the RAM port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2,
    GNT_FORCE = 2'd3
  } grant_e;

  // Both write grants pop the queue head and drive the RAM write port.
  function automatic logic is_write_grant(input grant_e g);
    return (g == GNT_WRITE) || (g == GNT_FORCE);
  endfunction

endpackage

// File: rtl/image_wr_fifo.sv
// Synchronous write queue for CPU pixel writes. A push while full and a pop
// while empty are ignored. Pointers wrap naturally because DEPTH is a power of 2.
module image_wr_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    push_en  = push && !full;
    pop_en   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state is cleared by reset; queued entries are simply forgotten.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/image_ram_arbiter.sv
// Image RAM port arbiter: scanout reads win, queued CPU writes fill idle
// cycles, and a starvation guard forces one write through when the queue has
// sat full behind reads for STARVE_LIMIT cycles.
// Optional feature macro: IMAGE_ARB_BLANK_ONLY_EN (normal writes only while
// active video is low; forced writes still happen).
//
// Write handshake: a word is accepted on a rising clk edge when wr_valid and
// wr_ready are both high; wr_ready is simply !full and does not depend on
// wr_valid. The master holds addr/data stable while wr_valid is high.
module image_ram_arbiter
  import image_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH    = 8,
  parameter int STARVE_LIMIT  = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDRESS_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          scan_req,
  input  logic [ADDRESS_WIDTH-1:0]      scan_addr,
  input  logic                          active,
  output logic                          scan_valid,
  output logic [DATA_WIDTH-1:0]         scan_data,
  output logic                          scan_miss,
  output logic [ADDRESS_WIDTH-1:0]      ram_addr,
  output logic                          ram_wEn,
  output logic [DATA_WIDTH-1:0]         ram_dataIn,
  input  logic [DATA_WIDTH-1:0]         ram_dataOut,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int FW = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

  grant_e                 grant;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FW-1:0]          fifo_head;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0]  head_data;
  logic                   push;
  logic                   pop;
  logic                   drain_ok;
  logic [SW-1:0]          starve_cnt_q, starve_cnt_d;
  logic                   scan_valid_q, scan_valid_d;
  logic                   scan_miss_q, scan_miss_d;

`ifdef IMAGE_ARB_BLANK_ONLY_EN
  assign drain_ok = !active;
`else
  logic unused_active;
  assign drain_ok      = 1'b1;
  assign unused_active = active;
`endif

  assign wr_ready  = !fifo_full;
  assign push      = wr_valid && !fifo_full;
  assign head_addr = fifo_head[FW-1:DATA_WIDTH];
  assign head_data = fifo_head[DATA_WIDTH-1:0];

  image_wr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Pick this cycle's RAM owner; nothing is granted while reset is high.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (fifo_full && scan_req && (starve_cnt_q == STARVE_MAX)) begin
        grant = GNT_FORCE;
      end else if (scan_req) begin
        grant = GNT_READ;
      end else if (!fifo_empty && drain_ok) begin
        grant = GNT_WRITE;
      end
    end
  end

  // Drive the RAM port from the grant; write grants pop the queue head.
  always_comb begin
    ram_addr   = scan_addr;
    ram_wEn    = 1'b0;
    ram_dataIn = head_data;
    pop        = 1'b0;
    if (is_write_grant(grant)) begin
      ram_addr = head_addr;
      ram_wEn  = 1'b1;
      pop      = 1'b1;
    end
  end

  // Count consecutive full cycles in which no write got through.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!fifo_full || is_write_grant(grant)) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
    scan_valid_d = (grant == GNT_READ);
    scan_miss_d  = (grant == GNT_FORCE);
  end

  // Registered scanout status and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      scan_valid_q <= 1'b0;
      scan_miss_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      scan_valid_q <= scan_valid_d;
      scan_miss_q  <= scan_miss_d;
    end
  end

  assign scan_valid = scan_valid_q;
  assign scan_miss  = scan_miss_q;
  assign scan_data  = ram_dataOut;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Directed bench for image_ram_arbiter with a behavioural 1-cycle image RAM.
module tb_image_ram_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int FD = 8;
  localparam int SL = 64;
  localparam int CW = $clog2(FD) + 1;

  // Clock / reset and DUT signals
  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          scan_req;
  logic [AW-1:0] scan_addr;
  logic          active;
  logic          scan_valid;
  logic [DW-1:0] scan_data;
  logic          scan_miss;
  logic [AW-1:0] ram_addr;
  logic          ram_wEn;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  image_ram_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (FD),
    .STARVE_LIMIT  (SL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .scan_req    (scan_req),
    .scan_addr   (scan_addr),
    .active      (active),
    .scan_valid  (scan_valid),
    .scan_data   (scan_data),
    .scan_miss   (scan_miss),
    .ram_addr    (ram_addr),
    .ram_wEn     (ram_wEn),
    .ram_dataIn  (ram_dataIn),
    .ram_dataOut (ram_dataOut),
    .fifo_count  (fifo_count)
  );

  // Image RAM model with a preload port
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  // Write monitor: every RAM write with the cycle it happened in
  int               cyc = 0;
  logic [AW+DW-1:0] got_q[$];
  int               wcyc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wEn) begin
      got_q.push_back({ram_addr, ram_dataIn});
      wcyc_q.push_back(cyc);
    end
  end

  // Scoreboard
  logic [AW+DW-1:0] exp_q[$];
  int               got_rd = 0;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: present one write for one cycle, expecting accept or refusal.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic expect_accept);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    check("wr_ready", 32'(wr_ready), 32'(expect_accept));
    if (expect_accept) exp_q.push_back({a, d});
    @(negedge clk);
  endtask

  // Wait (bounded) until the queue has drained.
  task automatic wait_empty();
    int k = 0;
    while (fifo_count != '0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(fifo_count), 32'd0);
  endtask

  // Compare logged RAM writes with the expected queue; optional cycle check.
  task automatic check_writes(input int first_cyc);
    int n_got;
    n_got = got_q.size() - got_rd;
    check("n_writes", 32'(n_got), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      check("write_word", 32'(got_q[got_rd+i]), 32'(exp_q[i]));
      if (first_cyc >= 0) check("write_cycle", 32'(wcyc_q[got_rd+i]), 32'(first_cyc + i));
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int miss_at;

    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    scan_req  = 1'b0;
    scan_addr = '0;
    active    = 1'b0;
    pre_en    = 1'b1;
    pre_addr  = 14'h0005;
    pre_data  = 8'hA5;
    @(negedge clk);
    pre_en = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_scan_valid", 32'(scan_valid), 32'd0);
    check("rst_scan_miss", 32'(scan_miss), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_ram_wen", 32'(ram_wEn), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Idle drain: three writes land on consecutive cycles, one after accept
    t0 = cyc;
    push(14'h0010, 8'h11, 1'b1);
    push(14'h0020, 8'h22, 1'b1);
    push(14'h3FFF, 8'hFF, 1'b1);
    wr_valid = 1'b0;
    wait_empty();
    check_writes(t0 + 1);

    // Scanout read priority and 1-cycle read latency
    scan_req  = 1'b1;
    scan_addr = 14'h0005;
    push(14'h0100, 8'h77, 1'b1);
    wr_valid = 1'b0;
    check("read_valid", 32'(scan_valid), 32'd1);
    check("read_data", 32'(scan_data), 32'hA5);
    check("read_queued", 32'(fifo_count), 32'd1);
    check("read_no_wen", 32'(ram_wEn), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("write_held", 32'(ram_wEn), 32'd0);
    end
    scan_req = 1'b0;
    #1;
    check("released_wen", 32'(ram_wEn), 32'd1);
    check("released_addr", 32'(ram_addr), 32'h0100);
    check("released_data", 32'(ram_dataIn), 32'h77);
    @(negedge clk);
    check("released_count", 32'(fifo_count), 32'd0);
    check("released_valid", 32'(scan_valid), 32'd0);
    check_writes(-1);

    // Fill under continuous scan_req, then starvation forced write
    scan_req  = 1'b1;
    scan_addr = 14'h0000;
    for (int i = 0; i < FD; i++) push(14'(32'h0200 + i), 8'(32'h30 + i), 1'b1);
    check("full_count", 32'(fifo_count), 32'd8);
    push(14'h3333, 8'hEE, 1'b0);
    wr_valid = 1'b0;
    check("full_ignored", 32'(fifo_count), 32'd8);
    miss_at = -1;
    for (int i = 1; i < 200; i++) begin
      if (i == 63) check("valid_before_force", 32'(scan_valid), 32'd1);
      if (scan_miss) begin
        miss_at = i;
        break;
      end
      @(negedge clk);
    end
    check("force_cycle", 32'(miss_at), 32'd64);
    check("force_valid", 32'(scan_valid), 32'd0);
    check("force_count", 32'(fifo_count), 32'd7);
    check("force_ready", 32'(wr_ready), 32'd1);
    check("force_n_writes", 32'(got_q.size() - got_rd), 32'd1);
    check("force_word", 32'(got_q[got_rd]), 32'({14'h0200, 8'h30}));
    @(negedge clk);
    check("miss_pulse", 32'(scan_miss), 32'd0);
    scan_req = 1'b0;
    wait_empty();
    check_writes(-1);

    // Simultaneous push and pop at count 4
    scan_req = 1'b1;
    for (int i = 0; i < 4; i++) push(14'(32'h0400 + i), 8'(32'h40 + i), 1'b1);
    check("pp_count_before", 32'(fifo_count), 32'd4);
    scan_req = 1'b0;
    push(14'h0404, 8'h44, 1'b1);
    check("pp_count_after", 32'(fifo_count), 32'd4);
    wr_valid = 1'b0;
    wait_empty();
    check_writes(-1);

    // Reset with queued writes: queue flushed, no writes while in reset
    scan_req = 1'b1;
    for (int i = 0; i < 5; i++) push(14'(32'h0500 + i), 8'(32'h50 + i), 1'b1);
    wr_valid = 1'b0;
    check("pre_reset_count", 32'(fifo_count), 32'd5);
    reset    = 1'b1;
    scan_req = 1'b0;
    #1;
    check("reset_wen", 32'(ram_wEn), 32'd0);
    @(negedge clk);
    check("post_reset_count", 32'(fifo_count), 32'd0);
    check("post_reset_valid", 32'(scan_valid), 32'd0);
    check("post_reset_miss", 32'(scan_miss), 32'd0);
    check("post_reset_ready", 32'(wr_ready), 32'd1);
    reset = 1'b0;
    exp_q.delete();
    check("lost_writes", 32'(got_q.size() - got_rd), 32'd0);
    got_rd = got_q.size();
    t0 = cyc;
    push(14'h0600, 8'h61, 1'b1);
    push(14'h0601, 8'h62, 1'b1);
    wr_valid = 1'b0;
    wait_empty();
    check_writes(t0 + 1);

    // Writes during active video
    active = 1'b1;
`ifdef IMAGE_ARB_BLANK_ONLY_EN
    push(14'h0700, 8'h71, 1'b1);
    push(14'h0701, 8'h72, 1'b1);
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("blank_hold_wen", 32'(ram_wEn), 32'd0);
      @(negedge clk);
    end
    check("blank_hold_count", 32'(fifo_count), 32'd2);
    active = 1'b0;
    #1;
    check("blank_release_wen", 32'(ram_wEn), 32'd1);
    t0 = cyc;
    wait_empty();
    check_writes(t0);
`else
    t0 = cyc;
    push(14'h0700, 8'h71, 1'b1);
    push(14'h0701, 8'h72, 1'b1);
    wr_valid = 1'b0;
    wait_empty();
    check_writes(t0 + 1);
    active = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
